prob1: RTL and testbench
========================

PROB1 -- requirements
Module: prob1

Interface
REQ-001 The block SHALL have parameter HALF_DIV, default 5, giving CLKin rising edges per CLKout half-period; legal range 1..8.
REQ-002 The block SHALL have port CLKin  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port CLKout  output  1  divided clock, period 2*HALF_DIV CLKin cycles, 50% duty.
REQ-005 The block SHALL have, only when PROB1_COUNT_OUT_EN is defined, port count  output  3  current internal divider count, declared after CLKout.
REQ-006 Port order SHALL be CLKin, RST, CLKout, then count when enabled, so positional instantiation (CLKin, RST, CLKout) is valid.

Function
REQ-007 The block SHALL hold a 3-bit counter cnt and a 1-bit register driving CLKout; CLKout SHALL be a direct register output with no combinational path from inputs.
REQ-008 On each CLKin rising edge with RST=0 and cnt < HALF_DIV-1, cnt SHALL increment by 1 and CLKout SHALL hold.
REQ-009 On each CLKin rising edge with RST=0 and cnt == HALF_DIV-1, cnt SHALL wrap to 0 and CLKout SHALL invert.
REQ-010 With default HALF_DIV=5: CLKout SHALL first go high on the 5th rising edge after RST deasserts, go low on the 10th, and repeat every 10 edges (divide-by-10).
REQ-011 HALF_DIV=1 SHALL toggle CLKout on every rising edge (divide-by-2).
REQ-012 Any cnt value >= HALF_DIV (unreachable in normal operation) SHALL be treated as terminal: next edge wraps cnt to 0 and toggles CLKout.
REQ-013 Count SHALL not saturate; wrap-around is the only terminal behaviour; no further state machine exists.

Reset
REQ-014 On a CLKin rising edge with RST=1, cnt SHALL become 0 and CLKout SHALL become 0, overriding counting and toggling.
REQ-015 RST asserted mid-period, including while CLKout=1, SHALL force CLKout=0 at that edge; counting SHALL restart from 0 on the first edge with RST=0.
REQ-016 RST held for multiple cycles SHALL keep cnt=0 and CLKout=0 throughout.
REQ-017 Before the first reset edge, output values are undefined; no asynchronous reset path SHALL exist.

Configuration
REQ-018 With macro PROB1_COUNT_OUT_EN defined, the block SHALL expose port count equal to cnt every cycle, reset value 0.
REQ-019 Without PROB1_COUNT_OUT_EN, port count SHALL not exist; CLKout behaviour SHALL be identical in both builds.

Verification
REQ-020 Power up CLKin=0 with a 10-unit period, RST=1 for one rising edge -> CLKout=0 (count=0 when enabled).
REQ-021 Release RST, then apply 5 rising edges -> CLKout goes 0->1 exactly at the 5th edge; count sequence 1,2,3,4,0.
REQ-022 Run 20 more edges -> CLKout toggles at edges 10, 15, 20, 25 after release (low, high, low, high); period 100 time units.
REQ-023 With CLKout=1, assert RST for one edge, then release -> CLKout=0 at the reset edge; next rise 5 edges after release.
REQ-024 HALF_DIV=1, RST released -> CLKout toggles every rising edge; HALF_DIV=8 -> toggle every 8 edges, count reaches 7.
REQ-025 Build with and without PROB1_COUNT_OUT_EN, running identical stimulus -> CLKout traces SHALL match cycle-for-cycle.

Source files
------------

// File: rtl/prob1.sv
// -----------------------------------------------------------------------------
// prob1 -- fixed-ratio clock divider
//
// Purpose
//   Divides CLKin by 2*HALF_DIV with a 50% duty cycle. A 3-bit counter counts
//   CLKin rising edges; every HALF_DIV edges it wraps to 0 and the output
//   register flips. CLKout comes straight from a flop, so it has no
//   combinational path from any input.
//
// Parameters
//   HALF_DIV   CLKin rising edges per CLKout half-period. Legal range is 1..8.
//
// Ports
//   CLKin   in   1  sole clock; every state update happens on its rising edge
//   RST     in   1  synchronous, active-high reset; forces cnt=0, CLKout=0
//   CLKout  out  1  divided clock, period 2*HALF_DIV CLKin cycles
//   count   out  3  present only when PROB1_COUNT_OUT_EN is defined; mirrors
//                   the internal counter each cycle (0 out of reset)
//
// Configuration
//   PROB1_COUNT_OUT_EN  when defined, adds the count port after CLKout.
//                       CLKout behaves identically in both builds.
//
// The port order (CLKin, RST, CLKout) is fixed so that positional
// instantiations written against the original block keep working.
// -----------------------------------------------------------------------------
module prob1 #(
  parameter int HALF_DIV = 5
) (
  input  logic       CLKin,
  input  logic       RST,
  output logic       CLKout
`ifdef PROB1_COUNT_OUT_EN
  ,
  output logic [2:0] count
`endif
);

  // Terminal count value. HALF_DIV=8 gives 7, which still fits in 3 bits.
  localparam logic [2:0] LAST = 3'(HALF_DIV - 1);

  logic [2:0] cnt;
  logic       clk_q;
  logic       at_last;

  // Using >= instead of == makes any out-of-range count (only reachable via
  // an upset or a pre-reset power-up value) behave as terminal, so the
  // divider recovers on the next edge instead of walking through the
  // remaining count space.
  assign at_last = (cnt >= LAST);

  always_ff @(posedge CLKin) begin
    if (RST) begin
      cnt   <= 3'd0;
      clk_q <= 1'b0;
    end else if (at_last) begin
      cnt   <= 3'd0;
      clk_q <= ~clk_q;
    end else begin
      cnt   <= cnt + 3'd1;
      clk_q <= clk_q;
    end
  end

  assign CLKout = clk_q;

`ifdef PROB1_COUNT_OUT_EN
  assign count = cnt;
`endif

endmodule

// File: tb/tb_prob1.sv
// -----------------------------------------------------------------------------
// tb_prob1 -- self-checking bench for prob1
//
// Three divider instances share one clock and reset:
//   dut    HALF_DIV=5 (default)  main table-driven sequence
//   dut_d1 HALF_DIV=1            divide-by-2
//   dut_d8 HALF_DIV=8            divide-by-16, counter reaches 7
// The count port is connected and checked only when PROB1_COUNT_OUT_EN is set.
// -----------------------------------------------------------------------------
module tb_prob1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic       clkout5, clkout1, clkout8;
  logic [2:0] count5, count1, count8;

`ifdef PROB1_COUNT_OUT_EN
  prob1 #(.HALF_DIV(5)) dut    (.CLKin(clk), .RST(rst), .CLKout(clkout5), .count(count5));
  prob1 #(.HALF_DIV(1)) dut_d1 (.CLKin(clk), .RST(rst), .CLKout(clkout1), .count(count1));
  prob1 #(.HALF_DIV(8)) dut_d8 (.CLKin(clk), .RST(rst), .CLKout(clkout8), .count(count8));
`else
  prob1 #(.HALF_DIV(5)) dut    (.CLKin(clk), .RST(rst), .CLKout(clkout5));
  prob1 #(.HALF_DIV(1)) dut_d1 (.CLKin(clk), .RST(rst), .CLKout(clkout1));
  prob1 #(.HALF_DIV(8)) dut_d8 (.CLKin(clk), .RST(rst), .CLKout(clkout8));
  assign count5 = 3'd0;
  assign count1 = 3'd0;
  assign count8 = 3'd0;
`endif

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check1(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check3(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
`ifdef PROB1_COUNT_OUT_EN
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
`else
    if (act !== exp) begin end
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       exp_out;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   edges_since_release = 0;

  // Expected state for HALF_DIV=5 after one edge with the given reset value.
  // With e edges since release: count = e mod 5, CLKout = (e div 5) mod 2.
  task automatic add_vec(input logic r);
    vec_t v;
    v.rst = r;
    if (r) begin
      edges_since_release = 0;
      v.exp_out = 1'b0;
      v.exp_cnt = 3'd0;
    end else begin
      edges_since_release++;
      v.exp_out = ((edges_since_release / 5) % 2) == 1;
      v.exp_cnt = 3'(edges_since_release % 5);
    end
    vecs.push_back(v);
  endtask

  // One edge: drive reset ahead of the edge, sample 1 time unit after it.
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    #1;
  endtask

  time t_rise15, t_rise25;

  initial begin
    // Power-up reset for one edge, then 25 edges of free running
    // (CLKout high at 5, low at 10, high 15, low 20, high 25).
    add_vec(1'b1);
    for (int i = 0; i < 25; i++) add_vec(1'b0);
    // Reset while CLKout=1 for one edge, then 7 edges (rise at 5th, count 2).
    add_vec(1'b1);
    for (int i = 0; i < 7; i++) add_vec(1'b0);
    // Mid-period reset held for three edges while CLKout=1, then recovery.
    for (int i = 0; i < 3; i++) add_vec(1'b1);
    for (int i = 0; i < 6; i++) add_vec(1'b0);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst);
      check1("clkout_div10", i, clkout5, vecs[i].exp_out);
      check3("count_div10", i, count5, vecs[i].exp_cnt);
      if (i == 15) t_rise15 = $time;
      if (i == 25) t_rise25 = $time;
    end

    // CLKout rises at edges 15 and 25 after release: one full period apart.
    checks++;
    if ((t_rise25 - t_rise15) != 100) begin
      errors++;
      $display("FAIL period_div10: got %0t, expected 100", t_rise25 - t_rise15);
    end

    // Hand sequence for the extreme divide ratios.
    step(1'b1);
    check1("clkout_d1_rst", 0, clkout1, 1'b0);
    check1("clkout_d8_rst", 0, clkout8, 1'b0);
    check3("count_d8_rst", 0, count8, 3'd0);
    for (int e = 1; e <= 20; e++) begin
      step(1'b0);
      check1("clkout_d1", e, clkout1, (e % 2) == 1);
      check3("count_d1", e, count1, 3'd0);
      check1("clkout_d8", e, clkout8, ((e / 8) % 2) == 1);
      check3("count_d8", e, count8, 3'(e % 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
